// File: rtl/io_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : io_cfg_sequencer
// Purpose  : Loads the user I/O ring's serial GPIO configuration chain.
//            One word is shifted out per pad, MSB first, and then the chain
//            load strobe is pulsed.
// Revision : 1.0 - initial release
// ============================================================================
module io_cfg_sequencer #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 4
) (
  input  logic                                              wb_clk_i,
  input  logic                                              wb_rst_i,
  input  logic                                              start,
  input  logic                                              abort,
  output logic [((NUM_PADS > 1) ? $clog2(NUM_PADS) : 1)-1:0] cfg_addr,
  input  logic [CFG_BITS-1:0]                               cfg_word,
  output logic                                              serial_clock,
  output logic                                              serial_data,
  output logic                                              serial_load,
  output logic                                              serial_resetn,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              aborted
);

  localparam int ADDR_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int BIT_W  = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int CNT_W  = $clog2(2 * CLK_DIV);

  localparam logic [CNT_W-1:0]  c_half      = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0]  c_half_m1   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  c_full_m1   = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] c_last_pad  = ADDR_W'(NUM_PADS - 1);
  localparam logic [BIT_W-1:0]  c_last_bit  = BIT_W'(CFG_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHAIN_RST = 3'd1,
    ST_FETCH     = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_LOAD      = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit;
  logic [ADDR_W-1:0]   r_pad;
  logic [ADDR_W-1:0]   r_cfg_addr;
  logic [CFG_BITS-1:0] r_shift;
  logic                r_serial_clock;
  logic                r_serial_data;
  logic                r_serial_load;
  logic                r_serial_resetn;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic [ADDR_W-1:0]   w_pad_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [CFG_BITS-1:0] w_shift_nxt;
  logic                w_abort_take;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit;
    w_pad_nxt    = r_pad;
    w_addr_nxt   = r_cfg_addr;
    w_shift_nxt  = r_shift;
    w_abort_take = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_CHAIN_RST;
          w_cnt_nxt   = '0;
          w_pad_nxt   = c_last_pad;
          w_addr_nxt  = c_last_pad;
        end
      end
      ST_CHAIN_RST: begin
        if (r_cnt == c_full_m1) begin
          w_state_nxt = ST_FETCH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_FETCH: begin
        // Address moves on to the next pad now so the lookup has the whole
        // shift period to settle before the next fetch.
        w_shift_nxt = cfg_word;
        w_bit_nxt   = c_last_bit;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_SHIFT;
        w_addr_nxt  = (r_pad == '0) ? '0 : r_pad - 1'b1;
      end
      ST_SHIFT: begin
        if (r_cnt == c_full_m1) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift << 1;
          if (r_bit == '0) begin
            if (r_pad == '0) begin
              w_state_nxt = ST_LOAD;
            end else begin
              w_pad_nxt   = r_pad - 1'b1;
              w_state_nxt = ST_FETCH;
            end
          end else begin
            w_bit_nxt = r_bit - 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_LOAD: begin
        if (r_cnt == c_half_m1) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == c_half_m1) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt  = ST_IDLE;
      w_abort_take = 1'b1;
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_bit           <= '0;
      r_pad           <= '0;
      r_cfg_addr      <= '0;
      r_shift         <= '0;
      r_serial_clock  <= 1'b0;
      r_serial_data   <= 1'b0;
      r_serial_load   <= 1'b0;
      r_serial_resetn <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_aborted       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_bit           <= w_bit_nxt;
      r_pad           <= w_pad_nxt;
      r_cfg_addr      <= w_addr_nxt;
      r_shift         <= w_shift_nxt;
      r_serial_clock  <= (w_state_nxt == ST_SHIFT) && (w_cnt_nxt >= c_half);
      r_serial_data   <= (w_state_nxt == ST_SHIFT) && w_shift_nxt[CFG_BITS-1];
      r_serial_load   <= (w_state_nxt == ST_LOAD);
      r_serial_resetn <= (w_state_nxt != ST_CHAIN_RST);
      r_busy          <= (w_state_nxt != ST_IDLE);
      r_done          <= (w_state_nxt == ST_DONE);
      r_aborted       <= w_abort_take;
    end
  end

  assign cfg_addr      = r_cfg_addr;
  assign serial_clock  = r_serial_clock;
  assign serial_data   = r_serial_data;
  assign serial_load   = r_serial_load;
  assign serial_resetn = r_serial_resetn;
  assign busy          = r_busy;
  assign done          = r_done;
  assign aborted       = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_io_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_cfg_sequencer
// Purpose  : Self-checking bench for io_cfg_sequencer across three parameter
//            sets (small, default, CLK_DIV=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_cfg_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] start;
  logic [2:0] abort;
  logic [2:0] busy, done, aborted, sclk, sdata, sload, sresetn;
  logic       addr0;
  logic [5:0] addr1;
  logic       addr2;
  logic [3:0] word0;
  logic [12:0] word1;
  logic [3:0] word2;
  logic [15:0] words [3][64];

  int checks;
  int errors;
  int cyc;
  int mj [3];
  logic mab [3];
  logic mpr [3];
  logic [1023:0] capv [3];
  int ncap [3], nviol [3], nrlow [3], nload [3], nbusy [3], ndone [3];
  int tdone [3], tstart [3];
  logic pclk [3], pdata [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous configuration lookups
  always @(posedge clk) begin
    word0 <= words[0][addr0][3:0];
    word1 <= words[1][addr1][12:0];
    word2 <= words[2][addr2][3:0];
  end

  io_cfg_sequencer #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(2)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start[0]), .abort(abort[0]),
    .cfg_addr(addr0), .cfg_word(word0), .serial_clock(sclk[0]),
    .serial_data(sdata[0]), .serial_load(sload[0]), .serial_resetn(sresetn[0]),
    .busy(busy[0]), .done(done[0]), .aborted(aborted[0]));

  io_cfg_sequencer #(.NUM_PADS(38), .CFG_BITS(13), .CLK_DIV(4)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start[1]), .abort(abort[1]),
    .cfg_addr(addr1), .cfg_word(word1), .serial_clock(sclk[1]),
    .serial_data(sdata[1]), .serial_load(sload[1]), .serial_resetn(sresetn[1]),
    .busy(busy[1]), .done(done[1]), .aborted(aborted[1]));

  io_cfg_sequencer #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(1)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start[2]), .abort(abort[2]),
    .cfg_addr(addr2), .cfg_word(word2), .serial_clock(sclk[2]),
    .serial_data(sdata[2]), .serial_load(sload[2]), .serial_resetn(sresetn[2]),
    .busy(busy[2]), .done(done[2]), .aborted(aborted[2]));

  function automatic int pn(int i); return (i == 1) ? 38 : 2; endfunction
  function automatic int pb(int i); return (i == 1) ? 13 : 4; endfunction
  function automatic int pc(int i); return (i == 0) ? 2 : ((i == 1) ? 4 : 1); endfunction

  function automatic int model_last(int i);
    return 4 * pc(i) + pn(i) * (1 + 2 * pc(i) * pb(i));
  endfunction

  // Expected {busy,done,aborted,sclk,sdata,sload,resetn} j edges after the
  // start-sampling edge, from the timeline arithmetic of a full load.
  function automatic logic [6:0] model_out(int i, int j, logic ab, logic pr);
    int n, b, c, s, slot, u, p, r, k;
    logic [15:0] w;
    n = pn(i); b = pb(i); c = pc(i);
    slot = 1 + 2 * c * b;
    s = 2 * c + n * slot;
    if (pr) return 7'b0000000;
    if (j < 0) return {2'b00, ab, 3'b000, 1'b1};
    if (j < 2 * c) return 7'b1000000;
    if (j < s) begin
      u = j - 2 * c;
      p = n - 1 - u / slot;
      r = u % slot;
      if (r == 0) return 7'b1000001;
      k = r - 1;
      w = words[i][p];
      return {3'b100, ((k % (2 * c)) >= c), w[b - 1 - k / (2 * c)], 2'b01};
    end
    if (j < s + c) return 7'b1000011;
    if (j < s + 2 * c) return 7'b1000001;
    return 7'b1100001;
  endfunction

  function automatic void model_update();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mj[i] = -1; mab[i] = 1'b0; mpr[i] = 1'b1;
      end else begin
        mpr[i] = 1'b0;
        mab[i] = 1'b0;
        if (mj[i] >= 0) begin
          if (abort[i]) begin
            mj[i] = -1; mab[i] = 1'b1;
          end else begin
            mj[i] = mj[i] + 1;
            if (mj[i] > model_last(i)) mj[i] = -1;
          end
        end else if (start[i]) begin
          mj[i] = 0;
        end
      end
    end
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      logic [6:0] e, a;
      e = model_out(i, mj[i], mab[i], mpr[i]);
      a = {busy[i], done[i], aborted[i], sclk[i], sdata[i], sload[i], sresetn[i]};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs inst%0d cycle %0d: got %b expected %b (busy,done,aborted,sclk,sdata,sload,resetn)",
                 i, cyc, a, e);
      end
      if (sclk[i] && !pclk[i]) begin
        if (ncap[i] < 1024) capv[i][ncap[i]] = sdata[i];
        ncap[i]++;
      end
      if (sclk[i] && (sdata[i] !== pdata[i])) nviol[i]++;
      if (!sresetn[i] && !rst && !mpr[i]) nrlow[i]++;
      if (sload[i]) nload[i]++;
      if (busy[i]) nbusy[i]++;
      if (done[i]) begin ndone[i]++; tdone[i] = cyc; end
      pclk[i] = sclk[i];
      pdata[i] = sdata[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_stats(int i);
    capv[i] = '0; ncap[i] = 0; nviol[i] = 0; nrlow[i] = 0;
    nload[i] = 0; nbusy[i] = 0; ndone[i] = 0; tdone[i] = 0;
  endtask

  task automatic pulse_start(int i);
    start[i] = 1'b1;
    tick();
    tstart[i] = cyc;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int target, int budget);
    int k;
    k = 0;
    while (ndone[i] < target && k < budget) begin
      tick();
      k++;
    end
    check("done_seen", ndone[i], target);
  endtask

  task automatic check_stream(int i);
    int bad, n, b;
    bad = 0; n = pn(i); b = pb(i);
    for (int slot = 0; slot < n; slot++)
      for (int k = 0; k < b; k++)
        if (capv[i][slot * b + k] !== words[i][n - 1 - slot][b - 1 - k]) bad++;
    check("stream_bad_bits", bad, 0);
    check("stream_rises", ncap[i], n * b);
  endtask

  initial begin
    rst = 1'b1; start = '0; abort = '0;
    cyc = 0; checks = 0; errors = 0;
    for (int i = 0; i < 3; i++) begin
      mj[i] = -1; mab[i] = 1'b0; mpr[i] = 1'b1;
      pclk[i] = 1'b0; pdata[i] = 1'b0;
      clear_stats(i);
      for (int p = 0; p < 64; p++) words[i][p] = 16'($urandom);
    end
    words[0][1] = 16'h000A; words[0][0] = 16'h0005;
    words[2][1] = 16'h0009; words[2][0] = 16'h0006;

    repeat (3) tick();
    check("rst_outs_inst0", {busy[0], done[0], aborted[0], sclk[0], sdata[0], sload[0], sresetn[0]}, 0);
    check("rst_resetn_all", sresetn, 0);
    check("rst_addr_inst1", addr1, 0);
    rst = 1'b0;
    tick();
    check("idle_resetn_all", sresetn, 3'b111);

    // Small chain: A then 5
    clear_stats(0);
    pulse_start(0);
    wait_done(0, 1, 200);
    tick();
    check("small_stream", capv[0][7:0], 8'hA5);
    check("small_rises", ncap[0], 8);
    check("small_resetn_low", nrlow[0], 4);
    check("small_load_high", nload[0], 2);
    check("small_busy_cycles", nbusy[0], 43);
    check("small_latency", tdone[0] - tstart[0], 42);

    // Default parameters with random words
    clear_stats(1);
    pulse_start(1);
    wait_done(1, 1, 6000);
    tick();
    check("dflt_latency", tdone[1] - tstart[1], 4006);
    check_stream(1);

    // Abort during pad 1, bit 2
    clear_stats(0);
    pulse_start(0);
    repeat (10) tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("abort_pulse", aborted[0], 1);
    check("abort_sclk", sclk[0], 0);
    check("abort_busy", busy[0], 0);
    repeat (50) tick();
    check("abort_no_done", ndone[0], 0);
    words[0][1] = 16'h0003; words[0][0] = 16'h000C;
    tick();
    clear_stats(0);
    pulse_start(0);
    wait_done(0, 1, 200);
    tick();
    check("reload_stream", capv[0][7:0], 8'h3C);
    check("reload_latency", tdone[0] - tstart[0], 42);

    // Start held through a whole load
    clear_stats(0);
    start[0] = 1'b1;
    tick();
    tstart[0] = cyc;
    repeat (43) tick();
    check("held_idle_busy", busy[0], 0);
    check("held_one_done", ndone[0], 1);
    tick();
    check("held_restart_busy", busy[0], 1);
    start[0] = 1'b0;
    wait_done(0, 2, 200);
    tick();
    check("held_second_latency", tdone[0] - tstart[0], 86);

    // Asynchronous reset while LOAD is active
    pulse_start(0);
    repeat (38) tick();
    check("load_active", sload[0], 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outs", {busy[0], done[0], aborted[0], sclk[0], sdata[0], sload[0], sresetn[0]}, 0);
    for (int i = 0; i < 3; i++) begin
      mj[i] = -1; mab[i] = 1'b0; mpr[i] = 1'b1;
    end
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_resetn", sresetn[0], 1);
    check("post_rst_busy", busy[0], 0);

    // CLK_DIV = 1
    clear_stats(2);
    pulse_start(2);
    wait_done(2, 1, 200);
    tick();
    check("div1_stream", capv[2][7:0], 8'h69);
    check("div1_rises", ncap[2], 8);
    check("div1_data_stable", nviol[2], 0);
    check("div1_latency", tdone[2] - tstart[2], 22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
